// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: opcodes, data widths and
// the arbiter FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_ABS = 3'b101;
    localparam logic [OP_W-1:0] OP_AVG = 3'b110;
    localparam logic [OP_W-1:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_CAPT = 2'b10,
        ST_RESP = 2'b11
    } arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the request, ALU and response channels of the ALU arbiter.
// slave  : the arbiter's view.
// master : the environment's view (requesters, ALU, response consumer).
interface alu_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    import alu_pkg::*;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*DATA_W-1:0] req_a_i;
    logic [NUM_REQ*DATA_W-1:0] req_b_i;
    logic [NUM_REQ*OP_W-1:0]   req_inst_i;

    logic [DATA_W-1:0]         alu_a_o;
    logic [DATA_W-1:0]         alu_b_o;
    logic [OP_W-1:0]           alu_inst_o;
    logic [RES_W-1:0]          alu_data_i;

    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [ID_W-1:0]           rsp_id_o;
    logic [RES_W-1:0]          rsp_data_o;
    logic                      rsp_err_o;
    logic                      busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_inst_i, alu_data_i, rsp_ready_i,
        output req_ready_o, alu_a_o, alu_b_o, alu_inst_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_inst_i, alu_data_i, rsp_ready_i,
        input  req_ready_o, alu_a_o, alu_b_o, alu_inst_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (mod NUM_REQ)
// and returns the first asserted request as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    // First valid requester after the pointer wins; ptr+i never exceeds
    // 2*NUM_REQ-1, so a single conditional subtract implements the modulo.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[ID_W-1:0];
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU (one-cycle latency) between NUM_REQ requesters.
// One operation in flight at a time, round-robin grant, result returned with
// the requester index on a valid/ready response channel.
// Optional macro ALU_DIVZERO_GUARD_EN: MOD with operand A == 0 is replaced by
// a harmless AND on the ALU and answered with data 0 and rsp_err_o = 1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; req_ready_o shows the round-robin grant
// EXEC  | captured operands drive the ALU; ALU registers at cycle end
// CAPT  | ALU result sampled into the response registers
// RESP  | response held until rsp_ready_i
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_p_i,
    input  logic               reset_n_i,
    alu_req_arbiter_if.slave   bus
);

    arb_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_inst;
    logic                dz_hit;
    logic                dz_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (bus.req_valid_i),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Pick the granted requester's payload out of the packed request buses.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_inst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a    = bus.req_a_i[i*DATA_W +: DATA_W];
                sel_b    = bus.req_b_i[i*DATA_W +: DATA_W];
                sel_inst = bus.req_inst_i[i*OP_W +: OP_W];
            end
        end
    end

`ifdef ALU_DIVZERO_GUARD_EN
    assign dz_hit = (sel_inst == OP_MOD) && (sel_a == '0);
`else
    // Without the guard nothing is ever flagged, so rsp_err_o stays 0 and a
    // modulo-by-zero result passes straight through from the ALU.
    assign dz_hit = 1'b0;
`endif

    // Grant is only offered while idle; at most one bit is ever set.
    assign bus.req_ready_o = (state == ST_IDLE) ? gnt : '0;

    // Arbiter FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= ST_IDLE;
            rr_ptr          <= ID_W'(NUM_REQ - 1);
            dz_q            <= 1'b0;
            bus.alu_a_o     <= '0;
            bus.alu_b_o     <= '0;
            bus.alu_inst_o  <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_id_o    <= '0;
            bus.rsp_data_o  <= '0;
            bus.rsp_err_o   <= 1'b0;
            bus.busy_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        bus.alu_a_o    <= sel_a;
                        bus.alu_b_o    <= sel_b;
                        bus.alu_inst_o <= dz_hit ? OP_AND : sel_inst;
                        bus.rsp_id_o   <= gnt_idx;
                        dz_q           <= dz_hit;
                        rr_ptr         <= gnt_idx;
                        bus.busy_o     <= 1'b1;
                        state          <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    bus.rsp_data_o  <= dz_q ? '0 : bus.alu_data_i;
                    bus.rsp_err_o   <= dz_q;
                    bus.rsp_valid_o <= 1'b1;
                    state           <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                        bus.busy_o      <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural registered ALU, requester and
// response-consumer model, directed scenarios followed by random traffic.
module tb_alu_req_arbiter;

    localparam int N = 2;

    logic clk;
    logic rst_n;

    alu_req_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_req_arbiter #(.NUM_REQ(N)) dut (
        .clk_p_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // requester model state
    bit   [N-1:0] pv;
    logic [7:0]   pa  [N];
    logic [7:0]   pb  [N];
    logic [2:0]   pop [N];
    int           last_g;
    logic [15:0]  last_data;
    int           last_id;
    logic         last_err;

    // behavioural ALU: SUB is b-a, MOD is b mod a (b when a is zero)
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        logic [7:0] t;
        case (op)
            3'd0: return 16'(a) + 16'(b);
            3'd1: return 16'(b) - 16'(a);
            3'd2: return 16'(a) * 16'(b);
            3'd3: return {8'h00, a & b};
            3'd4: return {8'h00, a ^ b};
            3'd5: begin t = a[7] ? (~a + 8'd1) : a; return {8'h00, t}; end
            3'd6: return (16'(a) + 16'(b)) >> 1;
            default: return (a == 8'd0) ? 16'(b) : 16'(b % a);
        endcase
    endfunction

    logic [15:0] alu_q;
    always @(posedge clk) alu_q <= alu_fn(bus.alu_a_o, bus.alu_b_o, bus.alu_inst_o);
    assign bus.alu_data_i = alu_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= N; k++) begin
            int c = (last_g + k) % N;
            if (pv[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int g);
        logic [31:0] v;
        v = 32'd0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid_i[i]      = pv[i];
            bus.req_a_i[i*8 +: 8]   = pa[i];
            bus.req_b_i[i*8 +: 8]   = pb[i];
            bus.req_inst_i[i*3 +: 3] = pop[i];
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
        pv[i]  = 1'b1;
        pa[i]  = a;
        pb[i]  = b;
        pop[i] = op;
    endtask

    task automatic new_op(input int i);
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) a = 8'h00;
        set_op(i, a, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    endtask

    // what the granted requester does once its operation has been accepted
    task automatic refresh(input int g, input int keep);
        if (keep == 0) pv[g] = 1'b0;
        else if (keep == 1) new_op(g);
        else begin
            if ($urandom_range(0, 1) == 1) new_op(g);
            else pv[g] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(0, 2) == 0) new_op(i);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_alu_a"},     32'(bus.alu_a_o), 0);
        chk({tag, "_alu_b"},     32'(bus.alu_b_o), 0);
        chk({tag, "_alu_inst"},  32'(bus.alu_inst_o), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 0);
        chk({tag, "_rsp_id"},    32'(bus.rsp_id_o), 0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data_o), 0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err_o), 0);
        chk({tag, "_busy"},      32'(bus.busy_o), 0);
        chk({tag, "_ready"},     32'(bus.req_ready_o), 0);
    endtask

    // One full operation, entered just after a negedge with the DUT idle and
    // the requester inputs driven. Checks every cycle up to the return to IDLE.
    task automatic transact(input int keep, input int rsp_delay, input bit noise);
        logic [7:0]  ea, eb;
        logic [2:0]  eop, einst;
        logic [15:0] edata;
        logic        eerr, dz;
        int          g, gn;
        g = model_grant();
        #1;
        chk("idle_busy", 32'(bus.busy_o), 0);
        chk("grant", 32'(bus.req_ready_o), onehot(g));
        if (g < 0) return;
        ea  = pa[g];
        eb  = pb[g];
        eop = pop[g];
        dz  = (eop == 3'b111) && (ea == 8'h00);
`ifdef ALU_DIVZERO_GUARD_EN
        einst = dz ? 3'b011 : eop;
        edata = dz ? 16'h0000 : alu_fn(ea, eb, eop);
        eerr  = dz;
`else
        einst = eop;
        edata = alu_fn(ea, eb, eop);
        eerr  = 1'b0;
`endif
        @(posedge clk);
        last_g = g;
        @(negedge clk);
        refresh(g, keep);
        drive();
        if (noise) bus.rsp_ready_i = 1'b1;
        #1;
        chk("exec_ready", 32'(bus.req_ready_o), 0);
        chk("exec_busy", 32'(bus.busy_o), 1);
        chk("exec_alu_a", 32'(bus.alu_a_o), 32'(ea));
        chk("exec_alu_b", 32'(bus.alu_b_o), 32'(eb));
        chk("exec_alu_inst", 32'(bus.alu_inst_o), 32'(einst));
        chk("exec_rsp_valid", 32'(bus.rsp_valid_o), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("capt_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("capt_ready", 32'(bus.req_ready_o), 0);
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        #1;
        chk("resp_valid", 32'(bus.rsp_valid_o), 1);
        chk("resp_id", 32'(bus.rsp_id_o), 32'(g));
        chk("resp_data", 32'(bus.rsp_data_o), 32'(edata));
        chk("resp_err", 32'(bus.rsp_err_o), 32'(eerr));
        chk("resp_ready", 32'(bus.req_ready_o), 0);
        last_data = bus.rsp_data_o;
        last_id   = int'(bus.rsp_id_o);
        last_err  = bus.rsp_err_o;
        for (int d = 0; d < rsp_delay; d++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(bus.rsp_valid_o), 1);
            chk("hold_data", 32'(bus.rsp_data_o), 32'(edata));
            chk("hold_id", 32'(bus.rsp_id_o), 32'(g));
            chk("hold_err", 32'(bus.rsp_err_o), 32'(eerr));
            chk("hold_ready", 32'(bus.req_ready_o), 0);
            chk("hold_busy", 32'(bus.busy_o), 1);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        #1;
        chk("done_valid", 32'(bus.rsp_valid_o), 0);
        chk("done_busy", 32'(bus.busy_o), 0);
        gn = model_grant();
        chk("done_ready", 32'(bus.req_ready_o), onehot(gn));
    endtask

    initial begin
        rst_n = 1'b0;
        pv    = '0;
        for (int i = 0; i < N; i++) begin
            pa[i]  = 8'h00;
            pb[i]  = 8'h00;
            pop[i] = 3'b000;
        end
        bus.rsp_ready_i = 1'b0;
        drive();
        last_g = N - 1;

        repeat (2) @(negedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single requesters, directed values
        set_op(0, 8'h03, 8'h05, 3'b000);
        drive();
        transact(0, 0, 1'b0);
        chk("add_data", 32'(last_data), 32'h0008);
        chk("add_id", 32'(last_id), 0);

        set_op(1, 8'h03, 8'h05, 3'b001);
        drive();
        transact(0, 0, 1'b0);
        chk("sub_data", 32'(last_data), 32'h0002);
        chk("sub_id", 32'(last_id), 1);

        set_op(1, 8'h10, 8'h10, 3'b010);
        drive();
        transact(0, 0, 1'b0);
        chk("mul_data", 32'(last_data), 32'h0100);

        // both requesters continuously valid: strict alternation
        new_op(0);
        new_op(1);
        drive();
        for (int k = 0; k < 4; k++) begin
            transact(1, 0, 1'b0);
            chk("alt_id", 32'(last_id), 32'(k % 2));
        end

        // response back-pressure, then drain with ready noise outside RESP
        transact(0, 5, 1'b0);
        transact(0, 0, 1'b1);
        chk("drained", 32'(pv), 0);

        // modulo by zero
        set_op(0, 8'h00, 8'h07, 3'b111);
        drive();
        transact(0, 0, 1'b0);
`ifdef ALU_DIVZERO_GUARD_EN
        chk("dz_data", 32'(last_data), 32'h0000);
        chk("dz_err", 32'(last_err), 1);
`else
        chk("dz_data", 32'(last_data), 32'h0007);
        chk("dz_err", 32'(last_err), 0);
`endif

        // reset during EXEC drops the operation
        set_op(0, 8'h21, 8'h42, 3'b100);
        drive();
        #1;
        chk("rx_grant", 32'(bus.req_ready_o), 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rx_exec_busy", 32'(bus.busy_o), 1);
        chk("rx_exec_alu_a", 32'(bus.alu_a_o), 32'h21);
        pv = '0;
        drive();
        rst_n = 1'b0;
        #1;
        check_reset("rst_exec");
        @(negedge clk);
        rst_n  = 1'b1;
        last_g = N - 1;
        new_op(0);
        new_op(1);
        drive();
        transact(0, 0, 1'b0);
        chk("rx_first_id", 32'(last_id), 0);
        transact(0, 1, 1'b0);
        chk("rx_second_id", 32'(last_id), 1);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            if (pv == '0) begin
                int idle = $urandom_range(0, 2);
                for (int c = 0; c < idle; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    #1;
                    chk("rnd_idle_ready", 32'(bus.req_ready_o), 0);
                    chk("rnd_idle_busy", 32'(bus.busy_o), 0);
                end
                new_op($urandom_range(0, N - 1));
                drive();
            end
            transact(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
